// File: rtl/swap_seq.sv
// swap_seq: multi-cycle sequencer for the SWAP instruction.
// Latches RS/RT on start, captures both operands from the register file's
// two read ports, then writes RS<-old RT and RT<-old RS on the single
// write port. Writes to R0 are suppressed because R0 is hardwired zero.
module swap_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [ADDR_W-1:0] rd_a_addr,
  output logic [ADDR_W-1:0] rd_b_addr,
  input  logic [DATA_W-1:0] rd_a_data,
  input  logic [DATA_W-1:0] rd_b_data,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WR_RS = 3'd2,
    WR_RT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] rs_lat_reg, rt_lat_reg;
  logic [DATA_W-1:0] tmp_a_reg, tmp_b_reg;

  // State register; reset abandons any swap in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Address latches (loaded on an accepted start) and operand temporaries
  // (loaded in READ, while the read ports still show the pre-swap values).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_lat_reg <= '0;
      rt_lat_reg <= '0;
      tmp_a_reg  <= '0;
      tmp_b_reg  <= '0;
    end else begin
      if (state_reg == IDLE && start) begin
        rs_lat_reg <= rs_addr;
        rt_lat_reg <= rt_addr;
      end
      if (state_reg == READ) begin
        tmp_a_reg <= rd_a_data;
        tmp_b_reg <= rd_b_data;
      end
    end
  end

  // Next-state and output decode; outputs depend only on registered state,
  // so busy/done and the write port are glitch-free and read 0 under reset.
  always_comb begin
    state_next = state_reg;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = READ;
      end
      READ: begin
        busy       = 1'b1;
        state_next = WR_RS;
      end
      WR_RS: begin
        busy       = 1'b1;
        rf_wr_addr = rs_lat_reg;
        rf_wr_data = tmp_b_reg;
        rf_wr_en   = |rs_lat_reg;  // R0 is never written
        state_next = WR_RT;
      end
      WR_RT: begin
        busy       = 1'b1;
        rf_wr_addr = rt_lat_reg;
        rf_wr_data = tmp_a_reg;
        rf_wr_en   = |rt_lat_reg;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rd_a_addr = rs_lat_reg;
  assign rd_b_addr = rt_lat_reg;

endmodule

// File: tb/tb_swap_seq.sv
// tb_swap_seq: directed bench for swap_seq with a small register-file model
// (combinational reads, R0 hardwired zero, write on rising edge).
module tb_swap_seq;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] rs_addr, rt_addr;
  logic [ADDR_W-1:0] rd_a_addr, rd_b_addr;
  logic [DATA_W-1:0] rd_a_data, rd_b_data;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic              busy, done;

  logic [DATA_W-1:0] rf [16];

  int checks   = 0;
  int failures = 0;

  swap_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rd_a_addr  (rd_a_addr),
    .rd_b_addr  (rd_b_addr),
    .rd_a_data  (rd_a_data),
    .rd_b_data  (rd_b_data),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: combinational read, write on rising edge.
  assign rd_a_data = (rd_a_addr == '0) ? '0 : rf[rd_a_addr];
  assign rd_b_data = (rd_b_addr == '0) ? '0 : rf[rd_b_addr];

  always @(posedge clk) begin
    if (rf_wr_en && rf_wr_addr != '0) rf[rf_wr_addr] <= rf_wr_data;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete swap starting at the next falling edge (cycle 0); returns
  // at the falling edge inside cycle 4 (DONE). va/vb are the hand-computed
  // old contents of RS/RT. With poke set, start is re-pulsed in cycles 2 and 4.
  task automatic do_swap(input string tag, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic en_rs, input logic en_rt, input bit poke);
    @(negedge clk);  // cycle 0
    start = 1'b1; rs_addr = rs; rt_addr = rt;
    check_val({tag, ".c0_busy"}, 32'(busy), 32'd0);
    @(negedge clk);  // cycle 1: READ
    start = 1'b0;
    check_val({tag, ".c1_busy"}, 32'(busy), 32'd1);
    check_val({tag, ".c1_wr_en"}, 32'(rf_wr_en), 32'd0);
    check_val({tag, ".c1_rd_a"}, 32'(rd_a_addr), 32'(rs));
    check_val({tag, ".c1_rd_b"}, 32'(rd_b_addr), 32'(rt));
    @(negedge clk);  // cycle 2: WR_RS
    if (poke) begin start = 1'b1; rs_addr = 4'd7; rt_addr = 4'd8; end
    check_val({tag, ".c2_wr_en"}, 32'(rf_wr_en), 32'(en_rs));
    check_val({tag, ".c2_wr_addr"}, 32'(rf_wr_addr), 32'(rs));
    check_val({tag, ".c2_wr_data"}, rf_wr_data, vb);
    check_val({tag, ".c2_busy"}, 32'(busy), 32'd1);
    @(negedge clk);  // cycle 3: WR_RT
    start = 1'b0;
    check_val({tag, ".c3_wr_en"}, 32'(rf_wr_en), 32'(en_rt));
    check_val({tag, ".c3_wr_addr"}, 32'(rf_wr_addr), 32'(rt));
    check_val({tag, ".c3_wr_data"}, rf_wr_data, va);
    check_val({tag, ".c3_done"}, 32'(done), 32'd0);
    @(negedge clk);  // cycle 4: DONE
    if (poke) begin start = 1'b1; rs_addr = 4'd7; rt_addr = 4'd8; end
    check_val({tag, ".c4_done"}, 32'(done), 32'd1);
    check_val({tag, ".c4_busy"}, 32'(busy), 32'd0);
    check_val({tag, ".c4_wr_en"}, 32'(rf_wr_en), 32'd0);
    check_val({tag, ".c4_wr_addr"}, 32'(rf_wr_addr), 32'd0);
    $display("swap %s rs=%0d rt=%0d done_at_cycle4=%0b", tag, rs, rt, done);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rs_addr = '0; rt_addr = '0;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    rf[1]  = 32'h1111_1111; rf[2]  = 32'h2222_2222;
    rf[3]  = 32'h1234_5678; rf[5]  = 32'hA5A5_A5A5;
    rf[4]  = 32'h0000_0044; rf[6]  = 32'h0000_0066;
    rf[7]  = 32'h0000_0077; rf[8]  = 32'h0000_0088;
    rf[9]  = 32'h0000_0099; rf[10] = 32'h0000_00AA;
    rf[11] = 32'hBBBB_0011; rf[12] = 32'hCCCC_0012;
    rf[13] = 32'hDDDD_0013; rf[14] = 32'hEEEE_0014;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst.busy", 32'(busy), 32'd0);
    check_val("rst.done", 32'(done), 32'd0);
    check_val("rst.wr_en", 32'(rf_wr_en), 32'd0);
    check_val("rst.rd_a", 32'(rd_a_addr), 32'd0);
    rst = 1'b0;

    // Basic swap R1<->R2
    do_swap("basic", 4'd1, 4'd2, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_val("basic.R1", rf[1], 32'h2222_2222);
    check_val("basic.R2", rf[2], 32'h1111_1111);

    // Same register
    do_swap("same", 4'd5, 4'd5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_val("same.R5", rf[5], 32'hA5A5_A5A5);

    // R0 protection
    do_swap("r0", 4'd0, 4'd3, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_val("r0.R3", rf[3], 32'h0000_0000);
    check_val("r0.R0", rf[0], 32'h0000_0000);

    // Start while busy and in DONE is ignored
    do_swap("busy_start", 4'd6, 4'd4, 32'h0000_0066, 32'h0000_0044, 1'b1, 1'b1, 1'b1);
    @(negedge clk);  // cycle 5
    start = 1'b0;
    check_val("busy_start.c5_busy", 32'(busy), 32'd0);
    check_val("busy_start.c5_done", 32'(done), 32'd0);
    @(negedge clk);
    check_val("busy_start.c6_busy", 32'(busy), 32'd0);
    check_val("busy_start.R6", rf[6], 32'h0000_0044);
    check_val("busy_start.R4", rf[4], 32'h0000_0066);
    check_val("busy_start.R7", rf[7], 32'h0000_0077);
    check_val("busy_start.R8", rf[8], 32'h0000_0088);

    // Reset during WR_RS
    @(negedge clk);
    start = 1'b1; rs_addr = 4'd9; rt_addr = 4'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);  // cycle 2: WR_RS
    check_val("mid_rst.pre_wr_en", 32'(rf_wr_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_val("mid_rst.wr_en", 32'(rf_wr_en), 32'd0);
    check_val("mid_rst.busy", 32'(busy), 32'd0);
    check_val("mid_rst.done", 32'(done), 32'd0);
    check_val("mid_rst.rd_a", 32'(rd_a_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("mid_rst.idle_busy", 32'(busy), 32'd0);
    check_val("mid_rst.R9", rf[9], 32'h0000_0099);
    check_val("mid_rst.R10", rf[10], 32'h0000_00AA);
    $display("swap mid_rst rs=9 rt=10 abandoned");
    do_swap("after_rst", 4'd9, 4'd10, 32'h0000_0099, 32'h0000_00AA, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_val("after_rst.R9", rf[9], 32'h0000_00AA);
    check_val("after_rst.R10", rf[10], 32'h0000_0099);

    // Back-to-back: second start lands at cycle 5 of the first swap
    do_swap("b2b_1", 4'd11, 4'd12, 32'hBBBB_0011, 32'hCCCC_0012, 1'b1, 1'b1, 1'b0);
    do_swap("b2b_2", 4'd13, 4'd14, 32'hDDDD_0013, 32'hEEEE_0014, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_val("b2b.R11", rf[11], 32'hCCCC_0012);
    check_val("b2b.R12", rf[12], 32'hBBBB_0011);
    check_val("b2b.R13", rf[13], 32'hEEEE_0014);
    check_val("b2b.R14", rf[14], 32'hDDDD_0013);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/swap_seq.md
# swap_seq

Multi-cycle sequencer that executes the SISC SWAP instruction by exchanging the contents of registers RS and RT through the register file's two read ports and single write port. On a start pulse it latches both addresses, captures both read operands into temporaries, then issues two write cycles, RS first and RT second. It sits between the control unit, which pulses `start`, and the register file write-address/data path. It is the write-side counterpart of the address-select logic that feeds swap addresses into the register file.

## Interface
- `DATA_W`, 32, register data width
- `ADDR_W`, 4, register address width (16 registers)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; one clock, asynchronous, active-high
- `start`  in  1  one-cycle request to begin a swap; sampled only in IDLE
- `rs_addr`  in  ADDR_W  RS address; sampled with `start`
- `rt_addr`  in  ADDR_W  RT address; sampled with `start`
- `rd_a_addr`  out  ADDR_W  register file read port A address (latched RS)
- `rd_b_addr`  out  ADDR_W  register file read port B address (latched RT)
- `rd_a_data`  in  DATA_W  read port A data (combinational from RF)
- `rd_b_data`  in  DATA_W  read port B data (combinational from RF)
- `rf_wr_en`  out  1  register file write enable
- `rf_wr_addr`  out  ADDR_W  register file write address
- `rf_wr_data`  out  DATA_W  register file write data
- `busy`  out  1  high while a swap is in progress (READ, WR_RS, WR_RT)
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, READ, WR_RS, WR_RT, DONE.
- IDLE: if `start`=1, latch `rs_addr` into `rs_lat` and `rt_addr` into `rt_lat`, then go to READ. Otherwise stay in IDLE.
- READ: capture `rd_a_data` into `tmp_a` and `rd_b_data` into `tmp_b`, then go to WR_RS.
- WR_RS: `rf_wr_addr`=`rs_lat`, `rf_wr_data`=`tmp_b`, `rf_wr_en`=1; then go to WR_RT.
- WR_RT: `rf_wr_addr`=`rt_lat`, `rf_wr_data`=`tmp_a`, `rf_wr_en`=1; then go to DONE.
- DONE: `done`=1; go to IDLE unconditionally.
- `rd_a_addr`=`rs_lat` and `rd_b_addr`=`rt_lat` at all times.
- R0 is hardwired zero. When the write-state address is 0, `rf_wr_en` stays 0 that cycle. Address and data are still driven.
- `rs_lat`==`rt_lat`: both writes are performed. Both carry the same value, so the register is unchanged.
- `start` outside IDLE (including DONE) is ignored and not queued.
- In IDLE and DONE: `rf_wr_en`=0, `rf_wr_addr`=0, `rf_wr_data`=0.
- Reset (async, any state): state←IDLE; `rs_lat`, `rt_lat`, `tmp_a`, `tmp_b`←0. All outputs read 0 while `rst`=1.
- A reset during WR_RS leaves the RT write unperformed. The swap is abandoned and the RF is left partially updated; this is acceptable because the control unit resets too.

## Timing
- Cycle 0: `start`=1 in IDLE.
- Cycle 1: READ; `busy`=1.
- Cycle 2: WR_RS write.
- Cycle 3: WR_RT write.
- Cycle 4: DONE; `done`=1, `busy`=0.
- Cycle 5: IDLE; a new `start` is accepted.
- Throughput: one swap per 5 cycles minimum; latency from `start` to `done` is 4 cycles.
- `busy` and `done` are decoded from the state register only, so they are glitch-free relative to `clk`.
- `rf_wr_*` are decoded from state and registered temporaries. The RF commits on the rising edge that ends the write cycle.
- The RS write commits before the RT read would matter. This is safe because both operands were captured in READ.
- Read data must be valid within the READ cycle, which relies on a combinational RF read.

## Test plan
- Basic swap: R1=0x11111111, R2=0x22222222; `start` with rs=1, rt=2 -> write R1←0x22222222 at cycle 2, write R2←0x11111111 at cycle 3, `done` at cycle 4, busy high for cycles 1–3.
- Same register: R5=0xA5A5A5A5, rs=rt=5 -> two writes of 0xA5A5A5A5 to address 5, R5 unchanged, `done` at cycle 4.
- R0 protection: rs=0, rt=3, R3=0x12345678 -> no write enable in WR_RS, R3←0x00000000 in WR_RT, R0 still 0.
- Start while busy: `start` pulsed at cycles 0 and 2 -> only one swap executes, exactly one `done`, IDLE at cycle 5.
- Reset mid-operation: `rst` asserted during WR_RS -> immediate IDLE; `rf_wr_en`, `busy` and `done` drop to 0 asynchronously; no WR_RT write occurs; a fresh swap after release completes normally.
- Back-to-back: `start` at cycles 0 and 5 with different address pairs -> two complete swaps, `done` at cycles 4 and 9, correct contents for both.
